pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the MIPS fetch path.
- Generates the fetch PC and sequences control transfers with the architectural one-instruction branch delay slot.
- Performs the branch-target addition: PC+4 plus the shifted sign-extended immediate.
- Also handles J/JAL and JR/JALR targets, and halts the core on a register jump to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, register-jump target that terminates execution.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze sequencer; all request inputs ignored while high.
- branch_taken  in  1  conditional branch at current pc resolved taken.
- extend_imm  in  32  sign-extended 16-bit branch offset, unshifted.
- jump  in  1  J/JAL at current pc.
- instr_index  in  26  J-type target field.
- jump_reg  in  1  JR/JALR at current pc.
- reg_target  in  32  rs value for register jump.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational.
- link_addr  out  32  pc + 8, combinational; JAL/JALR return address.
- active  out  1  high while executing.
- fault  out  1  sticky misaligned-target error.

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset (reset_n low, any time, including mid-DELAY):
  - pc=RESET_VECTOR, state=SEQ, active=1, fault=0, latched target cleared.
  - Takes effect immediately, without a clock edge.
- States:
  - SEQ: normal sequential fetch.
  - DELAY: delay slot being fetched; target is latched.
  - HALT: terminal; pc frozen, active=0, exited only by reset.
- All state, pc and target updates occur only on rising clk edges with stall=0.
- With stall=1 nothing changes; a request held across a stall is acted on at the first unstalled edge.
- SEQ, no request: pc <= pc+4.
- SEQ, request present:
  - Priority when several asserted: jump_reg > jump > branch_taken.
  - Branch target = pc_plus4 + (extend_imm << 2), 32-bit wrap-around, carry discarded.
  - Jump target = {pc_plus4[31:28], instr_index, 2'b00}.
  - Register-jump target = reg_target.
  - Latch the target, pc <= pc+4 (delay slot), state <= DELAY.
- SEQ, jump_reg with reg_target[1:0] != 0:
  - fault <= 1, active <= 0, state <= HALT; pc not advanced.
  - Delay slot is not fetched.
- DELAY:
  - All requests ignored; branch-in-delay-slot is a no-op.
  - Next unstalled edge: pc <= latched target.
  - If the transfer was jump_reg with target == HALT_ADDR: state <= HALT and active <= 0 on the same edge (pc = HALT_ADDR); otherwise state <= SEQ.
- HALT: outputs held (pc, active=0, fault value); all inputs ignored.
- pc+4 and pc+8 wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- Latency:
  - Taken transfer at pc P gives fetch sequence P, P+4, target, with no bubbles.
  - Each unstalled cycle advances pc exactly once.
- Branch-not-taken (branch_taken=0) is plain sequential flow.

Test Plan:
- Reset then 3 unstalled edges -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; active=1, fault=0; link_addr at BFC00000 = BFC00008.
- At pc=BFC00010, branch_taken=1, extend_imm=FFFFFFFC -> next pc BFC00014 (delay), then BFC00004 (BFC00014 + FFFFFFF0); branch_taken asserted during DELAY ignored.
- At pc=BFC00020, jump=1, instr_index=26'h0000100 -> pc BFC00024, then B0000400. Same cycle with branch_taken=1 and jump_reg=1, reg_target=00001000 -> jump_reg wins, pc BFC00024 then 00001000.
- jump_reg with reg_target=0 at pc=BFC00040 -> pc BFC00044, then pc=00000000 with active=0. Further edges and requests leave pc=0, active=0.
- jump_reg with reg_target=00001002 -> same edge fault=1, active=0, pc unchanged. Assert reset_n=0 mid-clock -> immediate pc=BFC00000, fault=0, active=1.
- stall=1 for 5 cycles during DELAY with target 00002000 -> pc holds at delay-slot address. First unstalled edge -> pc=00002000. Random extend_imm sweep (100 values) -> branch target == pc+4+(imm<<2) mod 2^32.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program counter with MIPS branch delay slot sequencing.
// Computes branch/jump/register-jump targets and halts on a register jump to HALT_ADDR.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] extend_imm,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {StSeq, StDelay, StHalt} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_target, w_target_d;
  logic        r_halt_on_target, w_halt_on_target_d;
  logic        r_fault, w_fault_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= StSeq;
      r_pc             <= RESET_VECTOR;
      r_target         <= '0;
      r_halt_on_target <= 1'b0;
      r_fault          <= 1'b0;
    end else begin
      r_state          <= w_state_d;
      r_pc             <= w_pc_d;
      r_target         <= w_target_d;
      r_halt_on_target <= w_halt_on_target_d;
      r_fault          <= w_fault_d;
    end
  end

  always_comb begin
    w_state_d          = r_state;
    w_pc_d             = r_pc;
    w_target_d         = r_target;
    w_halt_on_target_d = r_halt_on_target;
    w_fault_d          = r_fault;
    if (!stall) begin
      unique case (r_state)
        StSeq: begin
          if (jump_reg) begin
            if (reg_target[1:0] != 2'b00) begin
              // Misaligned register target: stop without fetching the delay slot.
              w_fault_d = 1'b1;
              w_state_d = StHalt;
            end else begin
              w_target_d         = reg_target;
              w_halt_on_target_d = (reg_target == HALT_ADDR);
              w_pc_d             = w_pc_plus4;
              w_state_d          = StDelay;
            end
          end else if (jump) begin
            w_target_d         = {w_pc_plus4[31:28], instr_index, 2'b00};
            w_halt_on_target_d = 1'b0;
            w_pc_d             = w_pc_plus4;
            w_state_d          = StDelay;
          end else if (branch_taken) begin
            w_target_d         = w_pc_plus4 + (extend_imm << 2);
            w_halt_on_target_d = 1'b0;
            w_pc_d             = w_pc_plus4;
            w_state_d          = StDelay;
          end else begin
            w_pc_d = w_pc_plus4;
          end
        end
        StDelay: begin
          w_pc_d    = r_target;
          w_state_d = r_halt_on_target ? StHalt : StSeq;
        end
        StHalt: begin
          w_state_d = StHalt;
        end
        default: begin
          w_state_d = StHalt;
        end
      endcase
    end
  end

  always_comb begin
    pc        = r_pc;
    pc_plus4  = w_pc_plus4;
    link_addr = r_pc + 32'd8;
    active    = (r_state != StHalt);
    fault     = r_fault;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected pc/active/fault,
// a monitor pops and compares after each clock edge or asynchronous sample.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] extend_imm = '0;
  logic        jump = 1'b0;
  logic [25:0] instr_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc, pc_plus4, link_addr;
  logic        active, fault;

  typedef struct {
    logic [31:0] pc;
    logic        act;
    logic        flt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  event ev_sample;

  pc_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .extend_imm   (extend_imm),
    .jump         (jump),
    .instr_index  (instr_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .link_addr    (link_addr),
    .active       (active),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Monitor: compare one queued expectation per edge or per asynchronous sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_sample);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4 || link_addr !== e.pc + 32'd8 ||
            active !== e.act || fault !== e.flt) begin
          n_fail++;
          $display("FAIL %s: got pc=%h p4=%h link=%h active=%b fault=%b, want pc=%h p4=%h link=%h active=%b fault=%b",
                   e.nm, pc, pc_plus4, link_addr, active, fault,
                   e.pc, e.pc + 32'd4, e.pc + 32'd8, e.act, e.flt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  function automatic void push(input logic [31:0] p, input logic a, input logic f,
                               input string nm);
    exp_t e;
    e.pc = p; e.act = a; e.flt = f; e.nm = nm;
    q.push_back(e);
  endfunction

  // Called at a negedge with inputs set; expectation applies after the next posedge.
  task automatic cyc(input logic [31:0] p, input logic a, input logic f, input string nm);
    push(p, a, f, nm);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, released at next negedge.
  task automatic do_reset(input string nm);
    #2 reset_n = 1'b0;
    #1 push(32'hBFC00000, 1'b1, 1'b0, nm);
    -> ev_sample;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clr();
    branch_taken = 0; jump = 0; jump_reg = 0; stall = 0;
  endtask

  initial begin
    logic [31:0] m_pc, imm, r, t;
    @(negedge clk);
    do_reset("reset_state");
    cyc(32'hBFC00004, 1, 0, "seq1");
    cyc(32'hBFC00008, 1, 0, "seq2");
    cyc(32'hBFC0000C, 1, 0, "seq3");
    cyc(32'hBFC00010, 1, 0, "seq4");

    // Backward branch; branch held during the delay slot must be ignored.
    branch_taken = 1; extend_imm = 32'hFFFFFFFC;
    cyc(32'hBFC00014, 1, 0, "br_delay");
    cyc(32'hBFC00004, 1, 0, "br_target");
    clr();
    for (int i = 1; i <= 7; i++) cyc(32'hBFC00004 + 32'(4 * i), 1, 0, "seq_to_20");

    jump = 1; instr_index = 26'h0000100;
    cyc(32'hBFC00024, 1, 0, "j_delay");
    cyc(32'hB0000400, 1, 0, "j_target");

    // All three requests: register jump must win.
    branch_taken = 1; jump = 1; jump_reg = 1; reg_target = 32'h00001000;
    cyc(32'hB0000404, 1, 0, "prio_delay");
    clr();
    cyc(32'h00001000, 1, 0, "prio_jr");

    // Stall in the delay slot with a branch asserted.
    jump_reg = 1; reg_target = 32'h00002000;
    cyc(32'h00001004, 1, 0, "stall_delay");
    jump_reg = 0; stall = 1; branch_taken = 1;
    for (int i = 0; i < 5; i++) cyc(32'h00001004, 1, 0, "stall_hold");
    stall = 0;
    cyc(32'h00002000, 1, 0, "stall_release");
    branch_taken = 0;

    // Request held across a stall in SEQ.
    stall = 1; jump = 1; instr_index = 26'h0001000;
    cyc(32'h00002000, 1, 0, "seq_stall1");
    cyc(32'h00002000, 1, 0, "seq_stall2");
    stall = 0;
    cyc(32'h00002004, 1, 0, "held_j_delay");
    jump = 0;
    cyc(32'h00004000, 1, 0, "held_j_target");

    m_pc = 32'h00004000;
    for (int i = 0; i < 100; i++) begin
      r = $urandom;
      imm = {{16{r[15]}}, r[15:0]};
      t = m_pc + 32'd4 + (imm << 2);
      branch_taken = 1; extend_imm = imm;
      cyc(m_pc + 32'd4, 1, 0, "sweep_delay");
      branch_taken = 0;
      cyc(t, 1, 0, "sweep_target");
      m_pc = t;
    end

    // Wrap-around of pc+4 / pc+8 at the top of the address space.
    jump_reg = 1; reg_target = 32'hFFFFFFF8;
    cyc(m_pc + 32'd4, 1, 0, "wrap_delay");
    jump_reg = 0;
    cyc(32'hFFFFFFF8, 1, 0, "wrap_fff8");
    cyc(32'hFFFFFFFC, 1, 0, "wrap_fffc");
    cyc(32'h00000000, 1, 0, "wrap_zero");

    // Register jump to 0 halts after the delay slot.
    jump_reg = 1; reg_target = 32'h00000000;
    cyc(32'h00000004, 1, 0, "halt_delay");
    jump_reg = 0;
    cyc(32'h00000000, 0, 0, "halt_enter");
    branch_taken = 1; jump = 1; jump_reg = 1; reg_target = 32'h00001002;
    for (int i = 0; i < 3; i++) cyc(32'h00000000, 0, 0, "halt_hold");
    clr();

    do_reset("reset_from_halt");
    jump_reg = 1; reg_target = 32'h00001002;
    cyc(32'hBFC00000, 0, 1, "misalign_fault");
    jump_reg = 0;
    cyc(32'hBFC00000, 0, 1, "fault_hold");
    do_reset("reset_clears_fault");

    jump = 1; instr_index = 26'h0000100;
    cyc(32'hBFC00004, 1, 0, "pre_reset_delay");
    jump = 0;
    do_reset("reset_mid_delay");
    cyc(32'hBFC00004, 1, 0, "after_reset_seq");

    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
